// File: rtl/gamepad_pmod_pkg.sv
// Shared definitions for the gamepad PMOD link, used by both the transmitter
// and the receiver side.
//   state_t      : transmitter FSM state encoding
//   btn_idx_t    : bit positions of each button inside a 12-bit controller word
//   FRAME_BITS   : serial bits per frame (two 12-bit controllers)
//   make_snapshot: builds the frame word; a missing controller reads as all ones
package gamepad_pmod_pkg;

  localparam int unsigned BTN_BITS   = 12;
  localparam int unsigned FRAME_BITS = 2 * BTN_BITS;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_CLK_LO = 3'd2,
    ST_CLK_HI = 3'd3,
    ST_GAP    = 3'd4
  } state_t;

  // Controller word order, MSB to LSB: {B,Y,SELECT,START,UP,DOWN,LEFT,RIGHT,A,X,L,R}
  typedef enum int unsigned {
    BTN_R      = 0,
    BTN_L      = 1,
    BTN_X      = 2,
    BTN_A      = 3,
    BTN_RIGHT  = 4,
    BTN_LEFT   = 5,
    BTN_DOWN   = 6,
    BTN_UP     = 7,
    BTN_START  = 8,
    BTN_SELECT = 9,
    BTN_Y      = 10,
    BTN_B      = 11
  } btn_idx_t;

  // Controller 0 occupies the upper half so it is shifted out first.
  function automatic logic [FRAME_BITS-1:0] make_snapshot(
    input logic [BTN_BITS-1:0] btn0,
    input logic [BTN_BITS-1:0] btn1,
    input logic                present0,
    input logic                present1
  );
    return {present0 ? btn0 : {BTN_BITS{1'b1}},
            present1 ? btn1 : {BTN_BITS{1'b1}}};
  endfunction

endpackage

// File: rtl/gamepad_pmod_tx_if.sv
// Serial PMOD link between the gamepad transmitter and its receiver.
//   pmod_latch : latch strobe, high during the latch phase
//   pmod_clk   : shift clock, receiver samples pmod_data on its rising edge
//   pmod_data  : serial data, active-high, MSB first
// master = transmitter (drives), slave = receiver (samples).
interface gamepad_pmod_tx_if;
  logic pmod_latch;
  logic pmod_clk;
  logic pmod_data;

  modport master (output pmod_latch, output pmod_clk, output pmod_data);
  modport slave  (input  pmod_latch, input  pmod_clk, input  pmod_data);
endinterface

// File: rtl/gamepad_pmod_tx.sv
// Gamepad PMOD transmitter: snapshots two 12-bit controller words and sends
// them as one 24-bit frame (latch strobe, 24 clock pulses, idle gap).
// Ports:
//   clk, reset        : system clock, asynchronous active-high reset
//   enable            : frames run back-to-back while high (sampled in IDLE only)
//   btn0, btn1        : controller button words, active-high
//   present0/present1 : controller-connected flags; absent reads as 12'hFFF
//   pmod              : latch / clock / data outputs (interface, master side)
//   busy              : high from latch phase through gap phase
//   frame_done        : one-cycle pulse as the FSM returns to IDLE
// Parameters: CLK_DIV (1..255) cycles per pmod_clk half-period,
//             GAP_CYCLES (1..1023) idle cycles after the last bit.
module gamepad_pmod_tx
  import gamepad_pmod_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [BTN_BITS-1:0]  btn0,
  input  logic [BTN_BITS-1:0]  btn1,
  input  logic                 present0,
  input  logic                 present1,
  gamepad_pmod_tx_if.master    pmod,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int unsigned LATCH_LEN = 2 * CLK_DIV;
  localparam int unsigned CNT_MAX   = (LATCH_LEN > GAP_CYCLES) ? LATCH_LEN : GAP_CYCLES;
  // Phase counter only ever counts 0..CNT_MAX-1, so it cannot wrap in a frame.
  localparam int unsigned CNT_W     = $clog2(CNT_MAX);
  localparam int unsigned BIT_W     = $clog2(FRAME_BITS);

  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_LEN - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [BIT_W-1:0] MSB_IDX    = BIT_W'(FRAME_BITS - 1);

  state_t                  state, state_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic [BIT_W-1:0]        bit_idx, bit_n;
  logic [FRAME_BITS-1:0]   shreg, shreg_n;
  logic                    latch_q, clk_q, data_q, busy_q, done_q;
  logic                    latch_n, clk_n, data_n, busy_n, done_n;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    bit_n   = bit_idx;
    shreg_n = shreg;
    done_n  = 1'b0;

    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (enable) begin
          state_n = ST_LATCH;
          shreg_n = make_snapshot(btn0, btn1, present0, present1);
        end
      end
      ST_LATCH: begin
        if (cnt == LATCH_LAST) begin
          state_n = ST_CLK_LO;
          cnt_n   = '0;
          bit_n   = MSB_IDX;
        end
      end
      ST_CLK_LO: begin
        if (cnt == HALF_LAST) begin
          state_n = ST_CLK_HI;
          cnt_n   = '0;
        end
      end
      ST_CLK_HI: begin
        if (cnt == HALF_LAST) begin
          cnt_n = '0;
          if (bit_idx == '0) begin
            state_n = ST_GAP;
          end else begin
            // Next bit moves into the MSB position as its low phase starts.
            state_n = ST_CLK_LO;
            bit_n   = bit_idx - 1'b1;
            shreg_n = {shreg[FRAME_BITS-2:0], 1'b0};
          end
        end
      end
      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    latch_n = (state_n == ST_LATCH);
    clk_n   = (state_n == ST_CLK_HI);
    data_n  = ((state_n == ST_CLK_LO) || (state_n == ST_CLK_HI)) && shreg_n[FRAME_BITS-1];
    busy_n  = (state_n != ST_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled before the edge.
  // NOTE: the snapshot register is small and its value is visible on
  // pmod_data, so it is reset along with the control state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      latch_q <= 1'b0;
      clk_q   <= 1'b0;
      data_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shreg   <= shreg_n;
      latch_q <= latch_n;
      clk_q   <= clk_n;
      data_q  <= data_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  assign pmod.pmod_latch = latch_q;
  assign pmod.pmod_clk   = clk_q;
  assign pmod.pmod_data  = data_q;
  assign busy            = busy_q;
  assign frame_done      = done_q;

endmodule

// File: tb/tb_gamepad_pmod_tx.sv
// Directed bench for gamepad_pmod_tx: a default instance (CLK_DIV=4, GAP=16)
// and a fast instance (CLK_DIV=1, GAP=1), each observed by a small receiver.
module tb_gamepad_pmod_tx;
  import gamepad_pmod_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        enable2 = 1'b0;
  logic [11:0] btn0 = '0;
  logic [11:0] btn1 = '0;
  logic        present0 = 1'b0;
  logic        present1 = 1'b0;
  logic        busy, frame_done, busy2, frame_done2;

  gamepad_pmod_tx_if pmod_if ();
  gamepad_pmod_tx_if pmod_if2 ();

  gamepad_pmod_tx #(.CLK_DIV(4), .GAP_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .btn0(btn0), .btn1(btn1), .present0(present0), .present1(present1),
    .pmod(pmod_if), .busy(busy), .frame_done(frame_done)
  );

  gamepad_pmod_tx #(.CLK_DIV(1), .GAP_CYCLES(1)) dut2 (
    .clk(clk), .reset(reset), .enable(enable2),
    .btn0(btn0), .btn1(btn1), .present0(present0), .present1(present1),
    .pmod(pmod_if2), .busy(busy2), .frame_done(frame_done2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Receiver models: clear on latch rise, shift in on pmod_clk rise.
  logic [23:0] rx_word = '0, rx2_word = '0;
  int          rx_cnt = 0, rx2_cnt = 0;

  always @(posedge pmod_if.pmod_latch) begin rx_word = '0; rx_cnt = 0; end
  always @(posedge pmod_if.pmod_clk) begin rx_word = {rx_word[22:0], pmod_if.pmod_data}; rx_cnt++; end
  always @(posedge pmod_if2.pmod_latch) begin rx2_word = '0; rx2_cnt = 0; end
  always @(posedge pmod_if2.pmod_clk) begin rx2_word = {rx2_word[22:0], pmod_if2.pmod_data}; rx2_cnt++; end

  // Cycle-level monitor, sampled on the falling edge.
  int   cyc = 0;
  int   latch_cycles = 0, fd_count = 0, rise_count = 0;
  int   fd_stamp [32];
  int   latch_rise [32];
  logic latch_prev = 1'b0;
  int   latch2_cycles = 0, fd2_count = 0, fd2_stamp = 0;

  always @(negedge clk) begin
    cyc++;
    if (pmod_if.pmod_latch) latch_cycles++;
    if (pmod_if.pmod_latch && !latch_prev && rise_count < 32) begin
      latch_rise[rise_count] = cyc;
      rise_count++;
    end
    latch_prev = pmod_if.pmod_latch;
    if (frame_done && fd_count < 32) begin
      fd_stamp[fd_count] = cyc;
      fd_count++;
    end
    if (pmod_if2.pmod_latch) latch2_cycles++;
    if (frame_done2) begin
      fd2_stamp = cyc;
      fd2_count++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_fd(input int target, input int budget, input string tag);
    int n = 0;
    while (fd_count < target && n < budget) begin step(); n++; end
    check({tag, "_timeout"}, 32'(fd_count >= target), 32'd1);
  endtask

  task automatic run_frame(input string tag, input logic [23:0] exp_word);
    int fd0, lat0, en_cyc;
    fd0  = fd_count;
    lat0 = latch_cycles;
    step();
    en_cyc = cyc;
    enable = 1'b1;
    step();
    enable = 1'b0;
    check({tag, "_latch_start"}, 32'(pmod_if.pmod_latch), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_fd(fd0 + 1, 400, tag);
    check({tag, "_word"}, 32'(rx_word), 32'(exp_word));
    check({tag, "_pulses"}, 32'(rx_cnt), 32'd24);
    check({tag, "_done_cycle"}, 32'(fd_stamp[fd0] - en_cyc), 32'd217);
    check({tag, "_latch_len"}, 32'(latch_cycles - lat0), 32'd8);
    repeat (30) step();
    check({tag, "_done_once"}, 32'(fd_count - fd0), 32'd1);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fd0, r0, en_cyc, n;

    // Reset state
    repeat (3) step();
    check("rst_latch", 32'(pmod_if.pmod_latch), 32'd0);
    check("rst_clk", 32'(pmod_if.pmod_clk), 32'd0);
    check("rst_data", 32'(pmod_if.pmod_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    reset = 1'b0;
    step();
    check("idle_no_enable", 32'(busy), 32'd0);

    // Basic frame, both controllers present, one-cycle enable pulse
    btn0 = 12'hA50; btn1 = 12'h3C3; present0 = 1'b1; present1 = 1'b1;
    run_frame("a", 24'hA503C3);

    // Absent controllers read as all ones
    present1 = 1'b0; btn1 = 12'h000;
    run_frame("p1_absent", 24'hA50FFF);
    present0 = 1'b0; present1 = 1'b1; btn1 = 12'h3C3;
    run_frame("p0_absent", 24'hFFF3C3);

    // Back-to-back frames with enable held
    present0 = 1'b1; btn0 = 12'hA50; btn1 = 12'h3C3;
    fd0 = fd_count;
    r0  = rise_count;
    step();
    enable = 1'b1;
    wait_fd(fd0 + 3, 900, "b2b");
    enable = 1'b0;
    check("b2b_period1", 32'(fd_stamp[fd0 + 1] - fd_stamp[fd0]), 32'd217);
    check("b2b_period2", 32'(fd_stamp[fd0 + 2] - fd_stamp[fd0 + 1]), 32'd217);
    check("b2b_rise1", 32'(latch_rise[r0 + 1] - fd_stamp[fd0]), 32'd1);
    check("b2b_rise2", 32'(latch_rise[r0 + 2] - fd_stamp[fd0 + 1]), 32'd1);
    check("b2b_word", 32'(rx_word), 32'hA503C3);
    repeat (250) step();
    check("b2b_stops", 32'(fd_count - fd0), 32'd3);

    // Inputs toggling during shifting do not disturb the snapshot
    fd0 = fd_count;
    step();
    en_cyc = cyc;
    enable = 1'b1;
    step();
    enable = 1'b0;
    n = 0;
    while (fd_count < fd0 + 1 && n < 400) begin
      btn0 = btn0 ^ 12'hFFF;
      present0 = ~present0;
      present1 = ~present1;
      step();
      n++;
    end
    check("toggle_timeout", 32'(fd_count >= fd0 + 1), 32'd1);
    check("toggle_word", 32'(rx_word), 32'hA503C3);
    check("toggle_done_cycle", 32'(fd_stamp[fd0] - en_cyc), 32'd217);
    btn0 = 12'hA50; present0 = 1'b1; present1 = 1'b1;
    repeat (5) step();

    // Reset at bit 10 while pmod_clk and pmod_data are both high
    btn1 = 12'h7C3;
    fd0 = fd_count;
    step();
    enable = 1'b1;
    step();
    enable = 1'b0;
    n = 0;
    while (rx_cnt < 14 && n < 400) begin step(); n++; end
    check("rst_mid_reach_bit10", 32'(rx_cnt), 32'd14);
    check("rst_mid_pre_clk", 32'(pmod_if.pmod_clk), 32'd1);
    check("rst_mid_pre_data", 32'(pmod_if.pmod_data), 32'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_latch", 32'(pmod_if.pmod_latch), 32'd0);
    check("rst_mid_clk", 32'(pmod_if.pmod_clk), 32'd0);
    check("rst_mid_data", 32'(pmod_if.pmod_data), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(frame_done), 32'd0);
    enable = 1'b1;
    repeat (5) step();
    check("rst_hold_no_done", 32'(fd_count - fd0), 32'd0);
    check("rst_hold_busy", 32'(busy), 32'd0);
    en_cyc = cyc;
    reset = 1'b0;
    step();
    enable = 1'b0;
    check("rst_restart_latch", 32'(pmod_if.pmod_latch), 32'd1);
    wait_fd(fd0 + 1, 400, "rst_restart");
    check("rst_restart_word", 32'(rx_word), 32'hA507C3);
    check("rst_restart_pulses", 32'(rx_cnt), 32'd24);
    check("rst_restart_done_cycle", 32'(fd_stamp[fd0] - en_cyc), 32'd217);
    btn1 = 12'h3C3;

    // Fast instance: CLK_DIV=1, GAP_CYCLES=1, START+DOWN+RIGHT pressed
    btn0 = 12'h150;
    fd0 = fd2_count;
    n = latch2_cycles;
    step();
    en_cyc = cyc;
    enable2 = 1'b1;
    step();
    enable2 = 1'b0;
    r0 = 0;
    while (fd2_count < fd0 + 1 && r0 < 200) begin step(); r0++; end
    check("fast_timeout", 32'(fd2_count >= fd0 + 1), 32'd1);
    check("fast_word", 32'(rx2_word), 32'h1503C3);
    check("fast_pulses", 32'(rx2_cnt), 32'd24);
    check("fast_done_cycle", 32'(fd2_stamp - en_cyc), 32'd52);
    check("fast_latch_len", 32'(latch2_cycles - n), 32'd2);
    check("fast_buttons",
          32'({rx2_word[12 + BTN_START], rx2_word[12 + BTN_UP], rx2_word[12 + BTN_DOWN],
               rx2_word[12 + BTN_LEFT], rx2_word[12 + BTN_RIGHT]}),
          32'b10101);
    repeat (10) step();
    check("fast_done_once", 32'(fd2_count - fd0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gamepad_pmod_tx.md
GAMEPAD_PMOD_TX -- requirements
Module: gamepad_pmod_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning system cycles per pmod_clk half-period (legal 1..255).
REQ-002 SHALL have parameter GAP_CYCLES, default 16, meaning idle cycles after the last bit before frame_done (legal 1..1023).
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-005 SHALL have port enable  input  1  level; frames are generated back-to-back while high.
REQ-006 SHALL have port btn0  input  12  controller 0 buttons, active-high, bit order {B,Y,SELECT,START,UP,DOWN,LEFT,RIGHT,A,X,L,R} at [11:0].
REQ-007 SHALL have port btn1  input  12  controller 1 buttons, same order.
REQ-008 SHALL have port present0, present1  input  1 each  controller-connected flags.
REQ-009 SHALL have port pmod_latch  output  1  latch strobe to the gamepad receiver.
REQ-010 SHALL have port pmod_clk  output  1  serial shift clock.
REQ-011 SHALL have port pmod_data  output  1  serial data, active-high.
REQ-012 SHALL have port busy  output  1  high from the latch phase through the gap phase.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse at end of each frame.

Function
REQ-014 SHALL implement FSM states IDLE, LATCH, CLK_LO, CLK_HI, GAP; all outputs registered.
REQ-015 In IDLE with enable=1, the next cycle SHALL enter LATCH, assert pmod_latch, and capture snapshot word {p0 ? btn0 : 12'hFFF, p1 ? btn1 : 12'hFFF} in the same edge.
REQ-016 LATCH SHALL hold pmod_latch=1, pmod_clk=0, pmod_data=0 for exactly 2*CLK_DIV cycles, then enter CLK_LO for bit 23.
REQ-017 CLK_LO SHALL drive pmod_clk=0 and pmod_data=current bit from its first cycle, for CLK_DIV cycles; CLK_HI SHALL drive pmod_clk=1 with pmod_data unchanged for CLK_DIV cycles (receiver samples on pmod_clk rise).
REQ-018 Bits SHALL be sent MSB first, snapshot bit 23 down to bit 0 (controller 0 first), exactly 24 pmod_clk pulses per frame.
REQ-019 After CLK_HI of bit 0, GAP SHALL drive pmod_clk=0, pmod_data=0 for GAP_CYCLES cycles; frame_done SHALL pulse on the last GAP cycle's successor, coincident with return to IDLE.
REQ-020 Deasserting enable mid-frame SHALL NOT truncate the frame; enable is sampled only in IDLE.
REQ-021 With enable held high, the next LATCH SHALL begin one cycle after frame_done (frame period 2*CLK_DIV + 48*CLK_DIV + GAP_CYCLES + 1 cycles).
REQ-022 btn/present changes after the snapshot edge SHALL NOT affect the frame in progress.
REQ-023 Bit and phase counters SHALL be sized from parameters, never wrap within a frame.

Reset
REQ-024 Reset assertion SHALL immediately (asynchronously) force IDLE, pmod_latch=0, pmod_clk=0, pmod_data=0, busy=0, frame_done=0, snapshot=0, counters=0.
REQ-025 Reset mid-frame SHALL abandon the frame with no frame_done; after release a fresh frame starts per REQ-015.

Structure
REQ-026 State encoding, button bit-index constants, and frame bit count (24) SHALL live in a shared package gamepad_pmod_pkg, shared with the receiver side.
REQ-027 SHALL be a single module with no sub-modules; a 24-bit shift register holds the snapshot.

Verification
REQ-028 CLK_DIV=4, GAP=16, btn0=12'hA50, btn1=12'h3C3, both present, enable pulse 1 cycle -> latch high 8 cycles, 24 clk pulses, receiver decodes 24'hA503C3, frame_done once at cycle 1+8+192+16.
REQ-029 present1=0, btn1=12'h000 -> bits 11..0 all ones (24'h<btn0>FFF); present0=0 -> upper 12 bits all ones.
REQ-030 enable held high 3 frames -> 3 frame_done pulses exactly 217 cycles apart, latch rises 1 cycle after each pulse.
REQ-031 btn0 toggled every cycle during shifting -> transmitted word equals value at snapshot edge.
REQ-032 reset asserted at bit 10 of a frame -> all outputs 0 same cycle, no frame_done; after release with enable=1, complete correct frame follows.
REQ-033 Loopback with the existing gamepad receiver, CLK_DIV=1 and 8 -> receiver start/up/down/left/right match btn0 inputs.
